// File: rtl/zone_cmd_scheduler.sv
// Queues resolver commands and releases them to the zone judge only during vertical blanking,
// starting at the vsync edge. Define ZONE_CMD_FLUSH_EN to treat code 8'hFF as a queue flush.
module zone_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned MAX_PER_FRAME = 4,
  parameter bit          VS_POL        = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_code,
  input  logic [31:0]                 in_para,
  output logic                        in_ready,
  input  logic                        vs,
  input  logic                        de,
  output logic                        out_valid,
  output logic [7:0]                  out_code,
  output logic [31:0]                 out_para,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic [7:0]                  drop_cnt
);
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [7:0]   MaxIssue = 8'(MAX_PER_FRAME);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [39:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [0:0]      state_q, state_d;
  logic [7:0]      issued_q, issued_d;
  logic [7:0]      drop_q;
  logic            vs_q, vs_act, frame_evt;
  logic            push, pop, drop, flush, empty;
  logic            out_valid_q;
  logic [7:0]      out_code_q;
  logic [31:0]     out_para_q;

`ifdef ZONE_CMD_FLUSH_EN
  assign flush = in_valid && (in_code == 8'hFF);
`else
  assign flush = 1'b0;
`endif

  assign vs_act    = (vs == VS_POL);
  assign frame_evt = vs_act && !vs_q;
  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != FullCnt);
  // in_ready uses the pre-pop count, so a full queue refuses a push even while popping.
  assign push      = in_valid && in_ready && !flush;
  assign drop      = in_valid && !in_ready && !flush;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_evt) begin
          state_d  = StIssue;
          issued_d = '0;
        end
      end
      StIssue: begin
        if (de || empty || (issued_q == MaxIssue) || flush) begin
          state_d = StIdle;
        end else begin
          pop      = 1'b1;
          issued_d = issued_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      issued_q    <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vs_q        <= 1'b0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_para_q  <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      count_q     <= count_d;
      vs_q        <= vs_act;
      out_valid_q <= pop;
      if (pop) begin
        out_code_q <= mem_q[rd_ptr_q][39:32];
        out_para_q <= mem_q[rd_ptr_q][31:0];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_code, in_para};
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_para  = out_para_q;
  assign pending   = count_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_zone_cmd_scheduler.sv
// Scoreboard bench for zone_cmd_scheduler: frames move modelled queue entries to an expected
// queue, and a negedge monitor compares every out_valid strobe against it.
module tb_zone_cmd_scheduler;
  localparam int unsigned Depth = 4;
  localparam int unsigned MaxPf = 3;

  logic        clk = 1'b0;
  logic        rst, in_valid, vs, de;
  logic [7:0]  in_code;
  logic [31:0] in_para;
  logic        in_ready, out_valid;
  logic [7:0]  out_code;
  logic [31:0] out_para;
  logic [2:0]  pending;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int passed   = 0;
  int exp_drop = 0;
  logic [39:0] model_q[$];
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  zone_cmd_scheduler #(
    .FIFO_DEPTH   (Depth),
    .MAX_PER_FRAME(MaxPf),
    .VS_POL       (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_para  (in_para),
    .in_ready (in_ready),
    .vs       (vs),
    .de       (de),
    .out_valid(out_valid),
    .out_code (out_code),
    .out_para (out_para),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest expected command.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) check("strobe_expected", 40'(exp_q.size()), 40'd1);
      else check("strobe_data", {out_code, out_para}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pending"}, 40'(pending), 40'(model_q.size()));
    check({tag, "_drop_cnt"}, 40'(drop_cnt), 40'(exp_drop));
    check({tag, "_in_ready"}, 40'(in_ready), 40'(model_q.size() < Depth));
  endtask

  task automatic push_cmd(input logic [7:0] c, input logic [31:0] p);
    check("push_in_ready", 40'(in_ready), 40'(model_q.size() < Depth));
    in_valid = 1'b1;
    in_code  = c;
    in_para  = p;
`ifdef ZONE_CMD_FLUSH_EN
    if (c == 8'hFF) model_q.delete();
    else
`endif
    if (model_q.size() < Depth) model_q.push_back({c, p});
    else exp_drop++;
    tick();
    in_valid = 1'b0;
    check("push_pending", 40'(pending), 40'(model_q.size()));
  endtask

  // de_off == 2 raises de one cycle after ISSUE is entered; -1 keeps de low.
  task automatic frame(input int de_off);
    int n;
    n = model_q.size();
    if (n > MaxPf) n = MaxPf;
    if (de_off == 2 && n > 1) n = 1;
    for (int i = 0; i < n; i++) exp_q.push_back(model_q.pop_front());
    vs = 1'b1;
    de = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == de_off) de = 1'b1;
      @(negedge clk);
      if (k < 2) check("early_strobe", 40'(out_valid), 40'd0);
      else check("strobe_at_t2", 40'(out_valid), 40'(n > 0));
      tick();
    end
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) tick();
    check("burst_drained", 40'(exp_q.size()), 40'd0);
    exp_q.delete();
    repeat (3) tick();
    vs = 1'b0;
    de = 1'b0;
    tick();
    tick();
    check_state("post_frame");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    in_para  = '0;
    vs       = 1'b0;
    de       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_out_valid", 40'(out_valid), 40'd0);
    check("reset_out_regs", {out_code, out_para}, 40'd0);
    check_state("reset");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_out_valid", 40'(out_valid), 40'd0);
      check("idle_pending", 40'(pending), 40'd0);
    end

    // Burst ordering with de toggling and vs inactive: nothing issued until the frame event.
    push_cmd(8'h01, 32'h11111111);
    de = 1'b1;
    push_cmd(8'h02, 32'h22222222);
    de = 1'b0;
    push_cmd(8'h03, 32'h33333333);
    de = 1'b1;
    repeat (3) tick();
    check("no_strobe_before_vs", 40'(out_valid), 40'd0);
    frame(-1);
    check("out_hold", {out_code, out_para}, {8'h03, 32'h33333333});

    // Overflow: two drops, then the cap splits the four survivors over two frames.
    for (int i = 0; i < 6; i++) push_cmd(8'(8'h10 + i), 32'hA0000000 + 32'(i));
    check_state("overflow");
    frame(-1);
    frame(-1);

    // de abort after one pop; the rest drains at the next frame.
    for (int i = 0; i < 4; i++) push_cmd(8'(8'h20 + i), 32'hB0000000 + 32'(i));
    frame(2);
    frame(-1);

`ifdef ZONE_CMD_FLUSH_EN
    for (int i = 0; i < 3; i++) push_cmd(8'(8'h30 + i), 32'hC0000000 + 32'(i));
    push_cmd(8'hFF, 32'hDEADBEEF);
    check_state("flush");
    frame(-1);
`else
    push_cmd(8'hFF, 32'hDEADBEEF);
    frame(-1);
`endif

    // Reset discards queued commands.
    push_cmd(8'h40, 32'h44444444);
    push_cmd(8'h41, 32'h55555555);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    exp_drop = 0;
    check("post_reset_out_valid", 40'(out_valid), 40'd0);
    check_state("mid_reset");
    frame(-1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/zone_cmd_scheduler.md
Name: zone_cmd_scheduler

Overview:
- Frame-synchronous command scheduler between the UART command resolver and the video zone judge.
- Queues decoded commands (code + 32-bit parameter list) in a small FIFO.
- Releases queued commands to the zone judge only during vertical blanking, starting at the frame's vsync edge. Zone updates therefore never tear mid-frame.
- Runs entirely in the pixel clock domain. Tracks commands that were dropped because the queue was full.

Parameters:
- FIFO_DEPTH, 4, queue depth in entries; must be a power of 2, at least 2.
- MAX_PER_FRAME, 4, maximum commands issued per vsync event; range 1..255.
- VS_POL, 1, vsync active polarity; 1 = active-high, 0 = active-low.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  command present from the UART resolver
- in_code  input  8  command code
- in_para  input  32  parameter list for the command
- in_ready  output  1  queue can accept a command this cycle
- vs  input  1  vertical sync from the timing generator
- de  input  1  active-video data enable
- out_valid  output  1  one-cycle strobe to the zone judge
- out_code  output  8  issued command code
- out_para  output  32  issued parameter list
- pending  output  $clog2(FIFO_DEPTH)+1  current queue occupancy
- drop_cnt  output  8  saturating count of commands lost to a full queue

Behaviour:
- Reset (rst sampled high at a clk edge):
  - FIFO empty; pending=0; drop_cnt=0.
  - out_valid=0; out_code=0; out_para=0.
  - State IDLE; internal vs history register = inactive level.
  - Reset mid-issue discards all queued commands. No out_valid in the cycle after reset.
- in_ready = (pending != FIFO_DEPTH), combinational.
- Push: occurs when in_valid && in_ready.
- Drop: occurs when in_valid && !in_ready.
  - drop_cnt increments and saturates at 255.
  - The command is discarded. There is no retry.
- Pop and push in the same cycle (non-full queue): both take effect; pending unchanged.
- When full, a push is refused even if a pop occurs that cycle, because in_ready is computed from the pre-pop count.
- Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- vsync edge detection:
  - vs_act = (vs == VS_POL).
  - vs_q is the registered copy of vs_act.
  - A frame event is vs_act && !vs_q.
- FSM:
  - IDLE: on a frame event go to ISSUE and clear the issued counter. Otherwise stay.
  - ISSUE, each cycle, in priority order:
    1. If de==1: go to IDLE, no pop.
    2. Else if the FIFO is empty, or issued == MAX_PER_FRAME: go to IDLE.
    3. Else: pop the head, register it to out_code/out_para, set out_valid=1 for the next cycle, increment issued.
  - A frame event seen while in ISSUE is ignored.
- Output registers:
  - out_valid is high for exactly one cycle per popped command. Consecutive pops give back-to-back strobes.
  - out_code and out_para hold their last issued value while out_valid=0.
- Latency: if the frame event is combinationally detected in cycle T, the first out_valid is high in cycle T+2.
- A command pushed during ISSUE may be issued in the same burst if it reaches the head before the stop condition.
- Empty queue at a frame event: the FSM visits ISSUE for one cycle and returns to IDLE with no strobe.
- pending is registered and reflects pushes and pops one cycle after they occur.

Optional Feature:
- Macro ZONE_CMD_FLUSH_EN.
- Defined:
  - An accepted input with in_code==8'hFF is a flush. It is not stored and not counted as a drop, even when the queue is full (in_ready is ignored for flush).
  - Flush empties the FIFO: pending=0 next cycle.
  - If a pop is scheduled in the same cycle, flush wins: no out_valid is produced and the FSM returns to IDLE.
- Undefined: code 0xFF is an ordinary command, queued and issued like any other.

Test Plan:
- Reset then idle: rst high 2 cycles, no stimulus -> out_valid=0, pending=0, drop_cnt=0, in_ready=1 throughout.
- Burst ordering: push codes 0x01,0x02,0x03 with para 0x11111111, 0x22222222, 0x33333333 while de toggles and vs is inactive -> no out_valid. At a vs rising edge with de=0, three consecutive out_valid strobes appear in order, the first at T+2; pending goes to 0.
- Overflow: FIFO_DEPTH=4; push 6 commands with no vs -> in_ready=0 after the 4th, drop_cnt=2. After a frame event, exactly the first 4 commands are issued.
- Per-frame cap: MAX_PER_FRAME=2, queue 3 commands, one frame event -> 2 strobes. The next frame event issues the 3rd.
- de abort: frame event with 4 queued and de rising 1 cycle after ISSUE is entered -> exactly 1 strobe, pending=3. The remaining commands are issued at the next frame event.
- Flush (ZONE_CMD_FLUSH_EN): queue 3 commands, then push code 0xFF -> pending=0, drop_cnt unchanged. The next frame event produces no strobe.
